// File: rtl/zsram_access_sequencer.sv
// Word-level read/write sequencer for the zero-second RAM cell array: setup, strobe and hold phases, plus a read response.
// Optional feature: define ZSRAM_READBACK_VERIFY_EN to re-read every written row and flag mismatches on VerifyError.
module zsram_access_sequencer #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 3
) (
  input  logic                         Crystal50Mhz1,
  input  logic                         Reset,
  input  logic                         RequestValid,
  output logic                         RequestReady,
  input  logic                         RequestWrite,
  input  logic [ADDR_WIDTH-1:0]        RequestAddress,
  input  logic [DATA_WIDTH-1:0]        RequestData,
  output logic                         ResponseValid,
  input  logic                         ResponseReady,
  output logic [DATA_WIDTH-1:0]        ResponseData,
  output logic [DATA_WIDTH-1:0]        CellInputData,
  output logic [(1<<ADDR_WIDTH)-1:0]   CellWriteEdge,
  output logic [(1<<ADDR_WIDTH)-1:0]   CellReadEdge,
  input  logic [DATA_WIDTH-1:0]        CellOutputData,
  output logic                         VerifyError
);

  localparam int ROWS = 1 << ADDR_WIDTH;

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : gSetupRange
    $error("SETUP_CYCLES must be within 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : gStrobeRange
    $error("STROBE_CYCLES must be within 1..15");
  end

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESPOND
`ifdef ZSRAM_READBACK_VERIFY_EN
    ,
    VERIFY_SETUP,
    VERIFY_STROBE,
    VERIFY_HOLD
`endif
  } stateT;

  stateT                 state, stateNext;
  logic [3:0]            cnt, cntNext;
  logic                  opWrite, opWriteNext;
  logic [ADDR_WIDTH-1:0] opAddr, opAddrNext;
  logic [DATA_WIDTH-1:0] inputDataNext, responseDataNext;
  logic [ROWS-1:0]       rowSel, writeEdgeNext, readEdgeNext;

`ifdef ZSRAM_READBACK_VERIFY_EN
  logic [DATA_WIDTH-1:0] capture, captureNext;
  logic                  verifyErrorNext;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    stateNext        = state;
    cntNext          = cnt;
    opWriteNext      = opWrite;
    opAddrNext       = opAddr;
    inputDataNext    = CellInputData;
    responseDataNext = ResponseData;
`ifdef ZSRAM_READBACK_VERIFY_EN
    captureNext      = capture;
    verifyErrorNext  = VerifyError;
`endif

    case (state)
      IDLE: begin
        if (RequestValid) begin
          opWriteNext = RequestWrite;
          opAddrNext  = RequestAddress;
          cntNext     = '0;
          stateNext   = SETUP;
          if (RequestWrite) inputDataNext = RequestData;
        end
      end
      SETUP: begin
        cntNext = cnt + 4'd1;
        if (cnt == SETUP_LAST) begin
          cntNext   = '0;
          stateNext = STROBE;
        end
      end
      STROBE: begin
        cntNext = cnt + 4'd1;
        if (cnt == STROBE_LAST) begin
          cntNext   = '0;
          stateNext = HOLD;
          // The read word is taken while the strobe is still high on its final cycle.
          if (!opWrite) responseDataNext = CellOutputData;
        end
      end
      HOLD: begin
        if (!opWrite)     stateNext = RESPOND;
`ifdef ZSRAM_READBACK_VERIFY_EN
        else              stateNext = VERIFY_SETUP;
`else
        else              stateNext = IDLE;
`endif
      end
      RESPOND: begin
        if (ResponseReady) stateNext = IDLE;
      end
`ifdef ZSRAM_READBACK_VERIFY_EN
      VERIFY_SETUP: begin
        cntNext = cnt + 4'd1;
        if (cnt == SETUP_LAST) begin
          cntNext   = '0;
          stateNext = VERIFY_STROBE;
        end
      end
      VERIFY_STROBE: begin
        cntNext = cnt + 4'd1;
        if (cnt == STROBE_LAST) begin
          cntNext     = '0;
          captureNext = CellOutputData;
          stateNext   = VERIFY_HOLD;
        end
      end
      VERIFY_HOLD: begin
        // CellInputData still carries the word just written.
        if (capture != CellInputData) verifyErrorNext = 1'b1;
        stateNext = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase

    rowSel         = '0;
    rowSel[opAddr] = 1'b1;
    writeEdgeNext  = (stateNext == STROBE && opWrite) ? rowSel : '0;
    readEdgeNext   = (stateNext == STROBE && !opWrite) ? rowSel : '0;
`ifdef ZSRAM_READBACK_VERIFY_EN
    if (stateNext == VERIFY_STROBE) readEdgeNext = rowSel;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Crystal50Mhz1) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      opWrite       <= 1'b0;
      opAddr        <= '0;
      RequestReady  <= 1'b1;
      ResponseValid <= 1'b0;
      ResponseData  <= '0;
      CellInputData <= '0;
      CellWriteEdge <= '0;
      CellReadEdge  <= '0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      opWrite       <= opWriteNext;
      opAddr        <= opAddrNext;
      RequestReady  <= (stateNext == IDLE);
      ResponseValid <= (stateNext == RESPOND);
      ResponseData  <= responseDataNext;
      CellInputData <= inputDataNext;
      CellWriteEdge <= writeEdgeNext;
      CellReadEdge  <= readEdgeNext;
    end
  end

`ifdef ZSRAM_READBACK_VERIFY_EN
  always_ff @(posedge Crystal50Mhz1) begin
    if (Reset) begin
      capture     <= '0;
      VerifyError <= 1'b0;
    end else begin
      capture     <= captureNext;
      VerifyError <= verifyErrorNext;
    end
  end
`else
  assign VerifyError = 1'b0;
`endif

endmodule

// File: tb/tb_zsram_access_sequencer.sv
// Randomized scoreboard bench for zsram_access_sequencer with a behavioural cell array and a cycle-window timing model.
// Covers the read-back verify path as well when ZSRAM_READBACK_VERIFY_EN is defined.
module tb_zsram_access_sequencer;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int S    = 2;
  localparam int ST   = 3;
  localparam int ROWS = 1 << AW;
`ifdef ZSRAM_READBACK_VERIFY_EN
  localparam int WRITE_LEN = 2 * (S + ST + 2) - 1;
`else
  localparam int WRITE_LEN = S + ST + 2;
`endif

  logic            clk = 1'b0;
  logic            Reset = 1'b1;
  logic            RequestValid = 1'b0;
  logic            RequestReady;
  logic            RequestWrite = 1'b0;
  logic [AW-1:0]   RequestAddress = '0;
  logic [DW-1:0]   RequestData = '0;
  logic            ResponseValid;
  logic            ResponseReady = 1'b0;
  logic [DW-1:0]   ResponseData;
  logic [DW-1:0]   CellInputData;
  logic [ROWS-1:0] CellWriteEdge;
  logic [ROWS-1:0] CellReadEdge;
  logic [DW-1:0]   CellOutputData;
  logic            VerifyError;

  zsram_access_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETUP_CYCLES(S), .STROBE_CYCLES(ST)
  ) dut (
    .Crystal50Mhz1 (clk),
    .Reset         (Reset),
    .RequestValid  (RequestValid),
    .RequestReady  (RequestReady),
    .RequestWrite  (RequestWrite),
    .RequestAddress(RequestAddress),
    .RequestData   (RequestData),
    .ResponseValid (ResponseValid),
    .ResponseReady (ResponseReady),
    .ResponseData  (ResponseData),
    .CellInputData (CellInputData),
    .CellWriteEdge (CellWriteEdge),
    .CellReadEdge  (CellReadEdge),
    .CellOutputData(CellOutputData),
    .VerifyError   (VerifyError)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural cell array: rows latch inputData while their write strobe is high; the
  // column bus carries junk unless a row is being read.
  logic [DW-1:0] cellMem [ROWS];
  logic [DW-1:0] junk = '0;
  logic [DW-1:0] stuckAnd = '1;

  always @(posedge clk) begin
    junk <= DW'($urandom);
    for (int i = 0; i < ROWS; i++) begin
      if (Reset) cellMem[i] <= '0;
      else if (CellWriteEdge[i]) cellMem[i] <= CellInputData;
    end
  end

  always_comb begin
    CellOutputData = junk;
    for (int i = 0; i < ROWS; i++)
      if (CellReadEdge[i]) CellOutputData = cellMem[i] & stuckAnd;
  end

  // Reference model: one outstanding operation, described by its accept cycle and the
  // windows that follow from the setup/strobe counts.
  logic [DW-1:0] refMem [ROWS];
  logic [DW-1:0] expQ [$];
  bit            opActive = 1'b0;
  int            opT = 0;
  bit            opW = 1'b0;
  int            opA = 0;
  logic [DW-1:0] opD = '0;
  logic [DW-1:0] expInput = '0;
  bit            expVerify = 1'b0;

  always @(negedge clk) begin : model
    logic [ROWS-1:0] expW, expR;
    bit expReady, expValid;
    if (armed) begin
      expW = '0; expR = '0; expReady = 1'b1; expValid = 1'b0;
      if (opActive) begin
        expReady = 1'b0;
        if (cyc >= opT + S + 1 && cyc <= opT + S + ST) begin
          if (opW) expW[opA] = 1'b1;
          else     expR[opA] = 1'b1;
        end
`ifdef ZSRAM_READBACK_VERIFY_EN
        if (opW && cyc >= opT + 2*S + ST + 2 && cyc <= opT + 2*S + 2*ST + 1) expR[opA] = 1'b1;
`endif
        if (!opW && cyc >= opT + S + ST + 2) expValid = 1'b1;
      end
      check("write_edge", 32'(CellWriteEdge), 32'(expW));
      check("read_edge", 32'(CellReadEdge), 32'(expR));
      check("request_ready", 32'(RequestReady), 32'(expReady));
      check("response_valid", 32'(ResponseValid), 32'(expValid));
      check("cell_input_data", 32'(CellInputData), 32'(expInput));
      check("verify_error", 32'(VerifyError), 32'(expVerify));

      if (Reset) begin
        opActive  = 1'b0;
        expInput  = '0;
        expVerify = 1'b0;
        expQ.delete();
        for (int i = 0; i < ROWS; i++) refMem[i] = '0;
      end else if (opActive) begin
        if (opW && cyc == opT + WRITE_LEN - 1) begin
`ifdef ZSRAM_READBACK_VERIFY_EN
          if ((opD & stuckAnd) != opD) expVerify = 1'b1;
`endif
          opActive = 1'b0;
        end else if (expValid && ResponseReady) begin
          opActive = 1'b0;
        end
      end else if (RequestValid) begin
        opActive = 1'b1;
        opT = cyc;
        opW = RequestWrite;
        opA = int'(RequestAddress);
        opD = RequestData;
        if (RequestWrite) begin
          refMem[opA] = RequestData;
          expInput    = RequestData;
        end else begin
          expQ.push_back(refMem[opA]);
        end
      end
    end
  end

  // Response monitor: whenever a word is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (armed && !Reset && ResponseValid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL response_unexpected at cycle %0d: got data %0h with no read outstanding", cyc, ResponseData);
      end else begin
        check("response_data", 32'(ResponseData), 32'(expQ[0]));
        if (ResponseReady) void'(expQ.pop_front());
      end
    end
  end

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d: event not seen within bound", name, cyc);
  endtask

  task automatic request(input bit w, input int a, input logic [DW-1:0] d,
                         input int rrDelay, input bit keepValid);
    int n;
    RequestValid   = 1'b1;
    RequestWrite   = w;
    RequestAddress = AW'(a);
    RequestData    = d;
    ResponseReady  = (rrDelay == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!RequestReady && n < 200);
    if (n >= 200) timeout("accept_timeout");
    @(posedge clk); #1;
    if (!keepValid) RequestValid = 1'b0;
    if (!w) begin
      n = 0;
      while (!ResponseValid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) timeout("response_timeout");
      repeat (rrDelay) @(posedge clk);
      #1 ResponseReady = 1'b1;
      @(posedge clk); #1;
      ResponseReady = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    Reset = 1'b1;
    @(posedge clk); #1 armed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_request_ready", 32'(RequestReady), 32'd1);
    check("rst_response_valid", 32'(ResponseValid), 32'd0);
    check("rst_response_data", 32'(ResponseData), 32'd0);
    check("rst_cell_input", 32'(CellInputData), 32'd0);
    check("rst_write_edge", 32'(CellWriteEdge), 32'd0);
    check("rst_read_edge", 32'(CellReadEdge), 32'd0);
    check("rst_verify_error", 32'(VerifyError), 32'd0);
    @(posedge clk); #1 Reset = 1'b0;

    request(1'b1, 5, 8'hA5, 0, 1'b0);
    request(1'b1, 9, 8'h3C, 0, 1'b0);
    request(1'b0, 9, 8'h00, 4, 1'b1);
    request(1'b0, 5, 8'h00, 0, 1'b0);

    // Reset lands while the row-3 write strobe is high.
    request(1'b1, 3, 8'h77, 0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (CellWriteEdge == '0 && n < 50);
    if (n >= 50) timeout("strobe_timeout");
    @(posedge clk); #1 Reset = 1'b1;
    @(posedge clk); #1 Reset = 1'b0;
    request(1'b0, 3, 8'h00, 1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      request(1'($urandom_range(0, 1)), int'($urandom_range(0, ROWS - 1)),
              DW'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    RequestValid = 1'b0;
    repeat (20) @(posedge clk);

`ifdef ZSRAM_READBACK_VERIFY_EN
    #1 stuckAnd = 8'hFE;
    request(1'b1, 6, 8'hFF, 0, 1'b0);
    repeat (20) @(posedge clk);
    request(1'b1, 7, 8'hFE, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1 Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    stuckAnd = '1;
    repeat (5) @(posedge clk);
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
